// File: rtl/tt_serial_sub_pkg.sv
// Shared types and pin map for the bit-serial subtractor tile.
package tt_serial_sub_pkg;

  // Controller states; encodings are fixed so they read the same in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // uio_in strobe positions
  localparam int PIN_LOAD_A = 0;
  localparam int PIN_LOAD_B = 1;
  localparam int PIN_START  = 2;

  // uio_out status positions
  localparam int PIN_BUSY   = 4;
  localparam int PIN_DONE   = 5;
  localparam int PIN_BORROW = 6;
  localparam int PIN_ZERO   = 7;

  // Upper nibble of uio is always driven, lower nibble is always input.
  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_serial_fs_bit.sv
// One-bit full-subtractor cell with its own registered borrow.
module tt_serial_fs_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic clear,
  input  logic enable,
  output logic d,
  output logic bw_next
);

  logic bw_reg;

  // Difference and borrow-out of a - b - borrow_in.
  always_comb begin
    d       = a ^ b ^ bw_reg;
    bw_next = (~a & b) | (~(a ^ b) & bw_reg);
  end

  // Borrow chain flop: cleared when a new operation launches, else follows bw_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bw_reg <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        bw_reg <= 1'b0;
      end else begin
        bw_reg <= bw_next;
      end
    end
  end

endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial 8-bit subtractor: D = A - B, LSB first, one bit per enabled clock.
module tt_um_serial_sub
  import tt_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] sh_a_reg, sh_b_reg, sh_d_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             start_q_reg;
  logic             borrow_reg;
  logic             zero_reg;

  logic             load_a, load_b, start_in, start_pulse;
  logic             load_ok, start_op, last_bit;
  logic             d_bit, bw_next;
  logic [WIDTH-1:0] a_src, b_src, d_shifted;
  logic             unused_ok;

  assign load_a      = uio_in[PIN_LOAD_A];
  assign load_b      = uio_in[PIN_LOAD_B];
  assign start_in    = uio_in[PIN_START];
  assign start_pulse = start_in & ~start_q_reg;
  assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));
  assign unused_ok   = &{1'b0, uio_in[7:3]};

  // A load in the same cycle as a start must reach the shift registers,
  // so the launch path takes the bus value directly.
  assign a_src     = (load_ok & load_a) ? ui_in : a_reg;
  assign b_src     = (load_ok & load_b) ? ui_in : b_reg;
  assign d_shifted = {d_bit, sh_d_reg[WIDTH-1:1]};

  tt_serial_fs_bit u_fs (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (sh_a_reg[0]),
    .b       (sh_b_reg[0]),
    .clear   (start_op),
    .enable  (ena & (start_op | (state_reg == ST_SHIFT))),
    .d       (d_bit),
    .bw_next (bw_next)
  );

  // Next-state and control decode.
  always_comb begin
    state_next = state_reg;
    load_ok    = 1'b0;
    start_op   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        load_ok = 1'b1;
        if (start_pulse) begin
          start_op   = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        load_ok = 1'b1;
        if (start_pulse) begin
          start_op   = 1'b1;
          state_next = ST_SHIFT;
        end else if (load_a | load_b) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, frozen while the tile is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else if (ena) begin
      state_reg <= state_next;
    end
  end

  // Operand capture, serial datapath and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q_reg <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sh_a_reg    <= '0;
      sh_b_reg    <= '0;
      sh_d_reg    <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      borrow_reg  <= 1'b0;
      zero_reg    <= 1'b0;
    end else if (ena) begin
      start_q_reg <= start_in;
      if (load_ok & load_a) begin
        a_reg <= ui_in;
      end
      if (load_ok & load_b) begin
        b_reg <= ui_in;
      end
      if (start_op) begin
        sh_a_reg <= a_src;
        sh_b_reg <= b_src;
        sh_d_reg <= '0;
        cnt_reg  <= '0;
      end else if (state_reg == ST_SHIFT) begin
        sh_a_reg <= sh_a_reg >> 1;
        sh_b_reg <= sh_b_reg >> 1;
        sh_d_reg <= d_shifted;
        cnt_reg  <= cnt_reg + 1'b1;
        if (last_bit) begin
          result_reg <= d_shifted;
          borrow_reg <= bw_next;
          zero_reg   <= (d_shifted == '0);
        end
      end
    end
  end

  // Output pin assembly.
  always_comb begin
    uo_out              = result_reg;
    uio_out             = 8'h00;
    uio_out[PIN_BUSY]   = (state_reg == ST_SHIFT);
    uio_out[PIN_DONE]   = (state_reg == ST_DONE);
    uio_out[PIN_BORROW] = borrow_reg;
    uio_out[PIN_ZERO]   = zero_reg;
    uio_oe              = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Scoreboard bench for the bit-serial subtractor tile.
module tb_tt_um_serial_sub;

  typedef struct packed {
    logic [7:0] d;
    logic       bw;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] a_m, b_m;
  int   nbusy;

  tt_um_serial_sub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] diff;
    diff = a - b;
    e.d  = diff;
    e.bw = (a < b);
    e.z  = (diff == 8'h00);
    return e;
  endfunction

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); ui_in = a; uio_in = 8'h01; a_m = a;
    @(negedge clk); ui_in = b; uio_in = 8'h02; b_m = b;
    @(negedge clk); uio_in = 8'h00;
  endtask

  task automatic start_op(input bit push);
    @(negedge clk); uio_in = 8'h04;
    if (push) sb.push_back(model(a_m, b_m));
    @(negedge clk); uio_in = 8'h00;
  endtask

  // Waits for done, counting busy samples, then compares against the scoreboard.
  task automatic wait_done(input string tag, output int busy_cycles);
    exp_t e;
    bit   got;
    got = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (uio_out[5]) begin
        got = 1'b1;
        break;
      end
      if (uio_out[4]) busy_cycles++;
      @(negedge clk);
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_d"}, uo_out, e.d);
      check({tag, "_borrow"}, uio_out[6], e.bw);
      check({tag, "_zero"}, uio_out[7], e.z);
      check({tag, "_busy_off"}, uio_out[4], 1'b0);
      check({tag, "_oe"}, uio_oe, 8'hF0);
      $display("txn %s: d=%02h borrow=%0b zero=%0b busy_cycles=%0d",
               tag, uo_out, uio_out[6], uio_out[7], busy_cycles);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    a_m = 8'h00; b_m = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    // 9 - 4
    load_ops(8'h09, 8'h04);
    start_op(1'b1);
    wait_done("9m4", nbusy);
    check("9m4_latency", nbusy, 8);

    // 4 - 9 with start held high for 20 cycles
    load_ops(8'h04, 8'h09);
    @(negedge clk); uio_in = 8'h04; sb.push_back(model(a_m, b_m));
    @(negedge clk);
    wait_done("4m9", nbusy);
    check("4m9_latency", nbusy, 8);
    repeat (11) @(negedge clk);
    check("hold_done", uio_out[5], 1'b1);
    check("hold_busy", uio_out[4], 1'b0);
    check("hold_sb_empty", sb.size(), 0);
    uio_in = 8'h00;

    // zero and wrap-around borrow
    load_ops(8'h80, 8'h80);
    start_op(1'b1);
    wait_done("80m80", nbusy);
    load_ops(8'h00, 8'h01);
    start_op(1'b1);
    wait_done("0m1", nbusy);

    // load and start during SHIFT are ignored
    load_ops(8'h3C, 8'h0F);
    start_op(1'b1);
    repeat (2) @(negedge clk);
    check("shift_uo_hold", uo_out, 8'hFF);
    ui_in = 8'hFF; uio_in = 8'h05;
    @(negedge clk); uio_in = 8'h00;
    wait_done("3Cm0F", nbusy);
    check("after_sb_empty", sb.size(), 0);
    start_op(1'b1);
    wait_done("3Cm0F_again", nbusy);

    // simultaneous load_a and start from DONE uses the new A
    @(negedge clk); ui_in = 8'h20; uio_in = 8'h05; a_m = 8'h20;
    sb.push_back(model(a_m, b_m));
    @(negedge clk); uio_in = 8'h00;
    wait_done("ld_start_20m0F", nbusy);

    // ena low for 5 cycles mid-SHIFT
    load_ops(8'hA5, 8'h5A);
    start_op(1'b1);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    check("ena_busy_hold", uio_out[4], 1'b1);
    check("ena_done_low", uio_out[5], 1'b0);
    ena = 1'b1;
    wait_done("ena_A5m5A", nbusy);
    check("ena_latency", nbusy, 8);

    // reset mid-SHIFT aborts
    load_ops(8'h55, 8'h11);
    start_op(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_uio", uio_out, 8'h00);
    check("midrst_oe", uio_oe, 8'hF0);
    @(negedge clk); rst_n = 1'b1;
    load_ops(8'h10, 8'h01);
    start_op(1'b1);
    wait_done("10m01", nbusy);
    check("10m01_latency", nbusy, 8);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
